// File: rtl/tuner_ctrl.sv
// Frame scheduler for the tuner pipeline: capture -> FFT -> find_freq -> evaluate.
// Applies a validity window and a stability filter before publishing the note.
module tuner_ctrl #(
  parameter int STABLE_COUNT = 3,
  parameter int MAX_DIFF     = 40,
  parameter int TIMEOUT      = 65535
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              run_i,
  input  logic              go_i,
  output logic              capture_start_o,
  input  logic              capture_done_i,
  output logic              fft_start_o,
  input  logic              fft_done_i,
  output logic              ff_enable_o,
  input  logic              ff_did_find_i,
  input  logic [2:0]        ff_note_i,
  input  logic signed [9:0] ff_difference_i,
  output logic [2:0]        note_out_o,
  output logic signed [9:0] diff_out_o,
  output logic              result_valid_o,
  output logic              locked_o,
  output logic              busy_o,
  output logic              timeout_err_o,
  output logic [1:0]        err_stage_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_CAP  = 3'd1,
    WAIT_FFT  = 3'd2,
    WAIT_FIND = 3'd3,
    EVAL      = 3'd4
  } state_t;

  localparam logic [15:0] TO_LOAD = 16'(TIMEOUT - 1);
  localparam logic [3:0]  SC      = 4'(STABLE_COUNT);
  localparam logic [10:0] MAXD    = 11'(MAX_DIFF);

  state_t             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               cs_q, cs_d;
  logic               fs_q, fs_d;
  logic               en_q, en_d;
  logic [2:0]         note_q, note_d;
  logic signed [9:0]  diff_q, diff_d;
  logic               rv_q, rv_d;
  logic               locked_q, locked_d;
  logic               busy_q, busy_d;
  logic               terr_q, terr_d;
  logic [1:0]         stage_q, stage_d;
  logic [3:0]         streak_q, streak_d;
  logic [2:0]         lnote_q, lnote_d;
  logic signed [9:0]  ldiff_q, ldiff_d;

  logic               tc;
  logic               abort;
  logic [1:0]         abort_stage;
  logic signed [10:0] diff_ext;
  logic [10:0]        diff_abs;
  logic               valid;

  // Absolute value in 11 bits so that -512 does not wrap back to a negative.
  assign diff_ext = {ldiff_q[9], ldiff_q};
  assign diff_abs = diff_ext[10] ? 11'(-diff_ext) : 11'(diff_ext);
  assign valid    = (ldiff_q != 10'sd511) && (diff_abs <= MAXD);
  assign tc       = (cnt_q == 16'd0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cs_d        = 1'b0;
    fs_d        = 1'b0;
    en_d        = en_q;
    note_d      = note_q;
    diff_d      = diff_q;
    rv_d        = 1'b0;
    locked_d    = locked_q;
    terr_d      = terr_q;
    stage_d     = stage_q;
    streak_d    = streak_q;
    lnote_d     = lnote_q;
    ldiff_d     = ldiff_q;
    abort       = 1'b0;
    abort_stage = 2'd0;

    case (state_q)
      IDLE: begin
        if (run_i || go_i) begin
          cs_d    = 1'b1;
          terr_d  = 1'b0;
          stage_d = 2'd0;
          cnt_d   = TO_LOAD;
          state_d = WAIT_CAP;
        end
      end
      WAIT_CAP: begin
        if (capture_done_i) begin
          fs_d    = 1'b1;
          cnt_d   = TO_LOAD;
          state_d = WAIT_FFT;
        end else if (tc) begin
          abort       = 1'b1;
          abort_stage = 2'd1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      WAIT_FFT: begin
        if (fft_done_i) begin
          en_d    = 1'b1;
          cnt_d   = TO_LOAD;
          state_d = WAIT_FIND;
        end else if (tc) begin
          abort       = 1'b1;
          abort_stage = 2'd2;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      WAIT_FIND: begin
        if (ff_did_find_i) begin
          en_d    = 1'b0;
          lnote_d = ff_note_i;
          ldiff_d = ff_difference_i;
          state_d = EVAL;
        end else if (tc) begin
          abort       = 1'b1;
          abort_stage = 2'd3;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      EVAL: begin
        if (valid) begin
          note_d = lnote_q;
          diff_d = ldiff_q;
          rv_d   = 1'b1;
          if (lnote_q == note_q) begin
            streak_d = (streak_q >= SC) ? SC : streak_q + 4'd1;
          end else begin
            streak_d = 4'd1;
          end
        end else begin
          streak_d = 4'd0;
        end
        locked_d = (streak_d >= SC);
        if (run_i) begin
          cs_d    = 1'b1;
          cnt_d   = TO_LOAD;
          state_d = WAIT_CAP;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      terr_d   = 1'b1;
      stage_d  = abort_stage;
      en_d     = 1'b0;
      streak_d = 4'd0;
      locked_d = 1'b0;
      state_d  = IDLE;
    end
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      cnt_q    <= 16'd0;
      cs_q     <= 1'b0;
      fs_q     <= 1'b0;
      en_q     <= 1'b0;
      note_q   <= 3'd0;
      diff_q   <= 10'sd0;
      rv_q     <= 1'b0;
      locked_q <= 1'b0;
      busy_q   <= 1'b0;
      terr_q   <= 1'b0;
      stage_q  <= 2'd0;
      streak_q <= 4'd0;
      lnote_q  <= 3'd0;
      ldiff_q  <= 10'sd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cs_q     <= cs_d;
      fs_q     <= fs_d;
      en_q     <= en_d;
      note_q   <= note_d;
      diff_q   <= diff_d;
      rv_q     <= rv_d;
      locked_q <= locked_d;
      busy_q   <= busy_d;
      terr_q   <= terr_d;
      stage_q  <= stage_d;
      streak_q <= streak_d;
      lnote_q  <= lnote_d;
      ldiff_q  <= ldiff_d;
    end
  end

  assign capture_start_o = cs_q;
  assign fft_start_o     = fs_q;
  assign ff_enable_o     = en_q;
  assign note_out_o      = note_q;
  assign diff_out_o      = diff_q;
  assign result_valid_o  = rv_q;
  assign locked_o        = locked_q;
  assign busy_o          = busy_q;
  assign timeout_err_o   = terr_q;
  assign err_stage_o     = stage_q;

endmodule

// File: tb/tb_tuner_ctrl.sv
// Bench for tuner_ctrl: scripted and randomized frames; a frame-level model
// predicts every output each cycle and a single compare process checks them.
module tb_tuner_ctrl;
  localparam int SC = 3;
  localparam int MD = 40;
  localparam int TO = 100;

  logic              clk_i = 1'b0;
  logic              rst_n_i = 1'b1;
  logic              run_i = 1'b0;
  logic              go_i = 1'b0;
  logic              capture_done_i = 1'b0;
  logic              fft_done_i = 1'b0;
  logic              ff_did_find_i = 1'b0;
  logic [2:0]        ff_note_i = 3'd0;
  logic signed [9:0] ff_difference_i = 10'sd0;
  logic              capture_start_o, fft_start_o, ff_enable_o;
  logic [2:0]        note_out_o;
  logic signed [9:0] diff_out_o;
  logic              result_valid_o, locked_o, busy_o, timeout_err_o;
  logic [1:0]        err_stage_o;

  tuner_ctrl #(.STABLE_COUNT(SC), .MAX_DIFF(MD), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .run_i(run_i), .go_i(go_i),
    .capture_start_o(capture_start_o), .capture_done_i(capture_done_i),
    .fft_start_o(fft_start_o), .fft_done_i(fft_done_i),
    .ff_enable_o(ff_enable_o), .ff_did_find_i(ff_did_find_i),
    .ff_note_i(ff_note_i), .ff_difference_i(ff_difference_i),
    .note_out_o(note_out_o), .diff_out_o(diff_out_o),
    .result_valid_o(result_valid_o), .locked_o(locked_o), .busy_o(busy_o),
    .timeout_err_o(timeout_err_o), .err_stage_o(err_stage_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  bit exp_cs, exp_fs, exp_en, exp_rv, exp_locked, exp_busy, exp_terr;
  int exp_note, exp_diff, exp_stage;
  int hist[$];
  bit noise = 1'b0;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_n_i) begin
      chk("capture_start", int'(capture_start_o), int'(exp_cs));
      chk("fft_start", int'(fft_start_o), int'(exp_fs));
      chk("ff_enable", int'(ff_enable_o), int'(exp_en));
      chk("result_valid", int'(result_valid_o), int'(exp_rv));
      chk("locked", int'(locked_o), int'(exp_locked));
      chk("busy", int'(busy_o), int'(exp_busy));
      chk("timeout_err", int'(timeout_err_o), int'(exp_terr));
      chk("err_stage", int'(err_stage_o), exp_stage);
      chk("note_out", int'(note_out_o), exp_note);
      chk("diff_out", int'(diff_out_o), exp_diff);
    end
  end

  function automatic bit is_valid(input int d);
    int a;
    a = (d < 0) ? -d : d;
    return (d != 511) && (a <= MD);
  endfunction

  // Length of the trailing run of identical valid notes since the last break.
  function automatic int run_len();
    int r;
    r = 0;
    if (hist.size() == 0) return 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] == hist[hist.size() - 1]) r++;
      else break;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
    exp_cs = 1'b0;
    exp_fs = 1'b0;
    exp_rv = 1'b0;
  endtask

  task automatic idle(input int n);
    run_i = 1'b0;
    go_i  = 1'b0;
    repeat (n) step();
  endtask

  task automatic wait_stage(input int st, input int n, input bit done_en);
    for (int k = 1; k <= n; k++) begin
      if (noise) begin
        go_i           = ($urandom_range(0, 3) == 0);
        capture_done_i = (st != 1) && ($urandom_range(0, 3) == 0);
        fft_done_i     = (st != 2) && ($urandom_range(0, 3) == 0);
        ff_did_find_i  = (st != 3) && ($urandom_range(0, 3) == 0);
      end
      case (st)
        1: capture_done_i = done_en && (k == n);
        2: fft_done_i     = done_en && (k == n);
        default: ff_did_find_i = done_en && (k == n);
      endcase
      step();
      go_i = 1'b0;
      capture_done_i = 1'b0;
      fft_done_i = 1'b0;
      ff_did_find_i = 1'b0;
      if (done_en && k == n) begin
        if (st == 1) exp_fs = 1'b1;
        else if (st == 2) exp_en = 1'b1;
        else exp_en = 1'b0;
      end else if (!done_en && k == TO) begin
        exp_terr = 1'b1;
        exp_stage = st;
        exp_en = 1'b0;
        exp_locked = 1'b0;
        exp_busy = 1'b0;
        hist.delete();
      end
    end
  endtask

  task automatic do_frame(input bit started, input bit use_go, input int lc, input int lf,
                          input int ld, input logic [2:0] n, input logic signed [9:0] d,
                          input bit run_eval, input int to_stage);
    if (!started) begin
      if (use_go) go_i = 1'b1;
      else run_i = 1'b1;
      step();
      go_i = 1'b0;
      exp_cs = 1'b1;
      exp_busy = 1'b1;
      exp_terr = 1'b0;
      exp_stage = 0;
    end
    if (to_stage != 0) run_i = 1'b0;
    ff_note_i = n;
    ff_difference_i = d;
    if (to_stage == 1) begin wait_stage(1, TO, 1'b0); return; end
    wait_stage(1, lc, 1'b1);
    if (!run_eval) run_i = 1'b0;
    if (to_stage == 2) begin wait_stage(2, TO, 1'b0); return; end
    wait_stage(2, lf, 1'b1);
    if (to_stage == 3) begin wait_stage(3, TO, 1'b0); return; end
    wait_stage(3, ld, 1'b1);
    run_i = run_eval;
    if (noise) go_i = ($urandom_range(0, 1) == 1);
    step();
    go_i = 1'b0;
    if (is_valid(int'(d))) begin
      exp_note = int'(n);
      exp_diff = int'(d);
      exp_rv = 1'b1;
      hist.push_back(int'(n));
    end else begin
      hist.delete();
    end
    exp_locked = (run_len() >= SC);
    exp_cs = run_eval;
    exp_busy = run_eval;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cs"}, int'(capture_start_o), 0);
    chk({tag, "_fs"}, int'(fft_start_o), 0);
    chk({tag, "_en"}, int'(ff_enable_o), 0);
    chk({tag, "_rv"}, int'(result_valid_o), 0);
    chk({tag, "_locked"}, int'(locked_o), 0);
    chk({tag, "_busy"}, int'(busy_o), 0);
    chk({tag, "_terr"}, int'(timeout_err_o), 0);
    chk({tag, "_stage"}, int'(err_stage_o), 0);
    chk({tag, "_note"}, int'(note_out_o), 0);
    chk({tag, "_diff"}, int'(diff_out_o), 0);
  endtask

  initial begin
    #1000000;
    n_errors++;
    $display("FAIL watchdog: got no finish, expected finish before 1ms");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit cont;
    int to, dsel, tmp;
    logic [2:0] nn, prev_n;
    logic signed [9:0] dd;

    #1 rst_n_i = 1'b0;
    #2 chk_all_zero("reset");
    #9 rst_n_i = 1'b1;
    idle(2);

    // Single go frame: note 2, diff -5.
    do_frame(1'b0, 1'b1, 10, 10, 4, 3'd2, -10'sd5, 1'b0, 0);
    idle(3);
    chk("t1_note", int'(note_out_o), 2);
    chk("t1_diff", int'(diff_out_o), -5);
    chk("t1_locked", int'(locked_o), 0);
    chk("t1_busy", int'(busy_o), 0);

    // Continuous run: three identical notes lock, a different note unlocks.
    do_frame(1'b0, 1'b0, 3, 4, 2, 3'd4, 10'sd3, 1'b1, 0);
    do_frame(1'b1, 1'b0, 2, 2, 3, 3'd4, 10'sd3, 1'b1, 0);
    chk("t2_locked_2nd", int'(locked_o), 0);
    do_frame(1'b1, 1'b0, 5, 1, 1, 3'd4, 10'sd3, 1'b1, 0);
    chk("t2_locked_3rd", int'(locked_o), 1);
    do_frame(1'b1, 1'b0, 1, 1, 1, 3'd1, 10'sd7, 1'b0, 0);
    chk("t2_locked_4th", int'(locked_o), 0);
    chk("t2_note_4th", int'(note_out_o), 1);
    idle(2);

    // Invalid results hold outputs and clear the streak.
    do_frame(1'b0, 1'b1, 2, 2, 2, 3'd3, 10'sd511, 1'b0, 0);
    do_frame(1'b0, 1'b1, 2, 2, 2, 3'd3, 10'sd60, 1'b0, 0);
    chk("t3_note_hold", int'(note_out_o), 1);
    chk("t3_diff_hold", int'(diff_out_o), 7);
    do_frame(1'b0, 1'b1, 1, 1, 1, 3'd1, 10'sd0, 1'b0, 0);
    do_frame(1'b0, 1'b1, 1, 1, 1, 3'd1, -10'sd40, 1'b0, 0);
    chk("t3_locked_after_clear", int'(locked_o), 0);
    do_frame(1'b0, 1'b1, 1, 1, 1, 3'd1, 10'sd40, 1'b0, 0);
    chk("t3_locked_relock", int'(locked_o), 1);
    idle(1);

    // FFT never completes: abort after TO cycles, next go clears the error.
    do_frame(1'b0, 1'b1, 4, 0, 0, 3'd0, 10'sd0, 1'b0, 2);
    chk("t4_terr", int'(timeout_err_o), 1);
    chk("t4_stage", int'(err_stage_o), 2);
    chk("t4_locked", int'(locked_o), 0);
    idle(3);
    do_frame(1'b0, 1'b1, 2, 2, 2, 3'd5, -10'sd41, 1'b0, 0);
    chk("t4_terr_cleared", int'(timeout_err_o), 0);
    chk("t4_stage_cleared", int'(err_stage_o), 0);

    // run dropped during WAIT_FFT: frame completes, no restart.
    do_frame(1'b0, 1'b0, 2, 6, 2, 3'd0, -10'sd12, 1'b0, 0);
    idle(5);
    chk("t5_busy", int'(busy_o), 0);
    chk("t5_note", int'(note_out_o), 0);

    // Asynchronous reset while find_freq is enabled.
    go_i = 1'b1;
    step();
    go_i = 1'b0;
    exp_cs = 1'b1; exp_busy = 1'b1; exp_terr = 1'b0; exp_stage = 0;
    wait_stage(1, 2, 1'b1);
    wait_stage(2, 2, 1'b1);
    wait_stage(3, 3, 1'b0);
    chk("t6_en_before_reset", int'(ff_enable_o), 1);
    #1 rst_n_i = 1'b0;
    #1 chk_all_zero("t6_async");
    exp_cs = 0; exp_fs = 0; exp_en = 0; exp_rv = 0; exp_locked = 0;
    exp_busy = 0; exp_terr = 0; exp_stage = 0; exp_note = 0; exp_diff = 0;
    hist.delete();
    #1 rst_n_i = 1'b1;
    idle(2);
    do_frame(1'b0, 1'b1, 3, 3, 3, 3'd3, 10'sd9, 1'b0, 0);
    chk("t6_note", int'(note_out_o), 3);
    chk("t6_diff", int'(diff_out_o), 9);
    idle(1);

    // Randomized frames with spurious done/go noise and occasional timeouts.
    noise = 1'b1;
    cont = 1'b0;
    prev_n = 3'd0;
    for (int i = 0; i < 40; i++) begin
      to = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
      nn = ($urandom_range(0, 2) != 0) ? prev_n : 3'($urandom_range(0, 5));
      prev_n = nn;
      dsel = int'($urandom_range(0, 7));
      case (dsel)
        0: tmp = 511;
        1: tmp = -512;
        2: tmp = 40;
        3: tmp = -40;
        4: tmp = 41;
        5: tmp = -41;
        default: tmp = int'($urandom_range(0, 60)) - 30;
      endcase
      dd = tmp[9:0];
      do_frame(cont, ($urandom_range(0, 1) == 1), int'($urandom_range(1, 8)),
               int'($urandom_range(1, 8)), int'($urandom_range(1, 8)), nn, dd,
               (i < 39) && (to == 0) && ($urandom_range(0, 1) == 1), to);
      cont = busy_o && exp_busy;
      if (!exp_busy) idle(int'($urandom_range(0, 2)));
    end
    noise = 1'b0;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
